clk_ratio_mon: RTL
==================

// Module: clk_ratio_mon
// PURPOSE
//  Receive-side companion of the clock divider. Measures the period of an
//  incoming divided clock in cycles of the reference CLK and reports it as a
//  ratio. Flags lock when the period is stable, and flags timeout when the
//  clock is stuck. Sits next to the divider output for self-check and
//  bring-up status.
// PARAMETERS
//  RATIO_WIDTH  5   width of RATIO_OUT; max reportable ratio 2^RATIO_WIDTH-1 (31)
//  TIMEOUT_CYC  40  CLK cycles without a detected rising edge before TIMEOUT
//  LOCK_MATCH   2   consecutive equal periods required to declare lock (>=2)
// PORTS
//  CLK        in   1            reference clock, rising-edge
//  RST        in   1            async active-low reset
//  MEAS_EN    in   1            1 = measure; 0 = return to IDLE
//  DIV_CLK_IN in   1            divided clock under test (async to CLK logic, 2-flop synced)
//  RATIO_OUT  out  RATIO_WIDTH  last locked period in CLK cycles
//  RATIO_VLD  out  1            1-cycle pulse when lock is (re)acquired
//  LOCKED     out  1            period stable at RATIO_OUT
//  TIMEOUT    out  1            no rising edge for TIMEOUT_CYC cycles
//  RANGE_ERR  out  1            sticky: measured period > 2^RATIO_WIDTH-1
// BEHAVIOUR
//  - Reset (RST=0, async): all outputs 0, counters 0, sync flops 0, state IDLE.
//  - DIV_CLK_IN -> 2-flop sync -> edge register; rise = sync_q & ~prev_q.
//    A detected rise lags the input edge by 2-3 CLK cycles. Only rises are used.
//  - Period P = number of CLK cycles between two consecutive detected rises.
//    The cycle counter is wide enough for TIMEOUT_CYC, restarts on each rise
//    and saturates at TIMEOUT_CYC.
//  - States:
//    - IDLE: counter cleared, LOCKED=0, TIMEOUT=0, RANGE_ERR cleared.
//      RATIO_OUT holds its last value. MEAS_EN=1 -> WAIT_EDGE.
//    - WAIT_EDGE: first rise -> MEASURE. No period is taken.
//    - MEASURE: on each rise, compute P.
//      - If P > 2^RATIO_WIDTH-1: set RANGE_ERR, clear match count.
//      - Else if P == previous P: increment match count. Otherwise match count = 1.
//      - When match count reaches LOCK_MATCH: RATIO_OUT <= P, LOCKED <= 1,
//        RATIO_VLD pulses for 1 cycle, go to LOCKED.
//    - LOCKED: keep measuring.
//      - P == RATIO_OUT: no change.
//      - P != RATIO_OUT (or out of range): LOCKED <= 0 on the next cycle, match
//        count = 1 with the new P, go to MEASURE. RATIO_OUT keeps its stale value.
//    - TIMEOUT: entered from WAIT_EDGE, MEASURE or LOCKED when the counter
//      reaches TIMEOUT_CYC with no rise. TIMEOUT <= 1, LOCKED <= 0, match
//      count cleared. A rise clears TIMEOUT and goes to MEASURE (the rise is a
//      start edge, no period).
//  - MEAS_EN=0 in any state: go to IDLE next cycle (overrides every other event).
//  - Rise and timeout terminal count in the same cycle: the rise wins.
//  - RATIO_VLD and the LOCKED rising edge occur in the same cycle. Registered
//    outputs, no combinational path from inputs.
//  - Ratio 1 (DIV_CLK_IN == CLK, pass-through) is not observable: the synced
//    sample is constant, so it results in TIMEOUT by design.
//  - Mid-operation RST=0: immediate return to reset values; measurement
//    restarts from WAIT_EDGE once RST=1 and MEAS_EN=1.
// TESTING
//  1. Drive the divider output at ratio 4, MEAS_EN=1 -> LOCKED=1, RATIO_OUT=4,
//     one RATIO_VLD pulse, after the 3rd detected rise.
//  2. Switch ratio 4 -> 5 while locked -> LOCKED drops after the first
//     5-cycle period, re-locks with RATIO_OUT=5 and a second RATIO_VLD.
//  3. Hold DIV_CLK_IN=0 (or ratio 1) -> TIMEOUT=1 after 40 cycles, LOCKED=0;
//     restore ratio 3 -> TIMEOUT clears on the first rise, LOCKED with RATIO_OUT=3.
//  4. Ratio 33 (period 33 < TIMEOUT_CYC) -> RANGE_ERR=1, LOCKED stays 0;
//     MEAS_EN=0 -> RANGE_ERR clears.
//  5. Odd ratios 3, 5, 31 with uneven duty cycle -> RATIO_OUT equals the
//     ratio in each case.
//  6. Assert RST=0 mid-measurement -> all outputs 0 asynchronously; release
//     -> re-lock needs 3 fresh rises. Also: MEAS_EN=0 while LOCKED -> LOCKED=0
//     next cycle, RATIO_OUT held.

Source files
------------

// File: rtl/clk_ratio_mon.sv
// clk_ratio_mon
// Receive-side companion of the clock divider. Measures the period of an
// incoming divided clock in reference-clock cycles and reports it as a ratio.
// LOCKED means the period is stable. TIMEOUT means the divided clock is stuck.
// RANGE_ERR is sticky and means a period was too long to report.

module clk_ratio_mon #(
    parameter int RATIO_WIDTH = 5,
    parameter int TIMEOUT_CYC = 40,
    parameter int LOCK_MATCH  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   meas_en_i,
    input  logic                   div_clk_i,
    output logic [RATIO_WIDTH-1:0] ratio_o,
    output logic                   ratio_vld_o,
    output logic                   locked_o,
    output logic                   timeout_o,
    output logic                   range_err_o
);

    localparam int CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int MATCH_W = $clog2(LOCK_MATCH + 1);
    localparam int PW      = (CNT_W > RATIO_WIDTH) ? CNT_W : RATIO_WIDTH;

    localparam logic [CNT_W-1:0]   CNT_TERM   = CNT_W'(TIMEOUT_CYC);
    localparam logic [PW-1:0]      RATIO_MAX  = PW'((1 << RATIO_WIDTH) - 1);
    localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_MATCH);
    localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_EDGE,
        ST_MEASURE,
        ST_LOCKED,
        ST_TIMEOUT
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [MATCH_W-1:0]     match_q, match_d;
    logic [RATIO_WIDTH-1:0] last_p_q, last_p_d;
    logic [RATIO_WIDTH-1:0] ratio_q, ratio_d;
    logic                   vld_q, vld_d;
    logic                   locked_q, locked_d;
    logic                   timeout_q, timeout_d;
    logic                   range_q, range_d;

    logic                   rise;
    logic                   cnt_term;
    logic [PW-1:0]          period;
    logic                   period_oor;
    logic [RATIO_WIDTH-1:0] period_short;
    logic [MATCH_W-1:0]     match_new;

    // The counter value at a rise is the period: it restarts at 1 on the
    // cycle after each rise and saturates at the timeout terminal count.
    assign rise         = sync2_q & ~prev_q;
    assign cnt_term     = (cnt_q == CNT_TERM);
    assign period       = PW'(cnt_q);
    assign period_oor   = (period > RATIO_MAX);
    assign period_short = RATIO_WIDTH'(cnt_q);

    // Double-flop synchroniser plus edge register for the divided clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= div_clk_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // State register and all registered measurement results.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            match_q   <= '0;
            last_p_q  <= '0;
            ratio_q   <= '0;
            vld_q     <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
            range_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
            last_p_q  <= last_p_d;
            ratio_q   <= ratio_d;
            vld_q     <= vld_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
            range_q   <= range_d;
        end
    end

    // Next-state logic. A rise always beats the timeout terminal count, and
    // dropping meas_en overrides everything and clears the status flags.
    always_comb begin
        state_d   = state_q;
        cnt_d     = rise ? CNT_W'(1) : (cnt_term ? cnt_q : cnt_q + CNT_W'(1));
        match_d   = match_q;
        last_p_d  = last_p_q;
        ratio_d   = ratio_q;
        vld_d     = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        range_d   = range_q;
        match_new = MATCH_ONE;

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                match_d   = '0;
                locked_d  = 1'b0;
                timeout_d = 1'b0;
                range_d   = 1'b0;
                if (meas_en_i) begin
                    state_d = ST_WAIT_EDGE;
                end
            end

            ST_WAIT_EDGE: begin
                if (rise) begin
                    match_d = '0;
                    state_d = ST_MEASURE;
                end else if (cnt_term) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    match_d   = '0;
                    state_d   = ST_TIMEOUT;
                end
            end

            ST_MEASURE: begin
                if (rise) begin
                    if (period_oor) begin
                        range_d = 1'b1;
                        match_d = '0;
                    end else begin
                        if ((match_q != '0) && (period_short == last_p_q)) begin
                            match_new = match_q + MATCH_ONE;
                        end
                        match_d  = match_new;
                        last_p_d = period_short;
                        if (match_new == MATCH_LOCK) begin
                            ratio_d  = period_short;
                            locked_d = 1'b1;
                            vld_d    = 1'b1;
                            state_d  = ST_LOCKED;
                        end
                    end
                end else if (cnt_term) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    match_d   = '0;
                    state_d   = ST_TIMEOUT;
                end
            end

            ST_LOCKED: begin
                if (rise) begin
                    if (period_oor) begin
                        range_d  = 1'b1;
                        match_d  = '0;
                        locked_d = 1'b0;
                        state_d  = ST_MEASURE;
                    end else if (period_short != ratio_q) begin
                        match_d  = MATCH_ONE;
                        last_p_d = period_short;
                        locked_d = 1'b0;
                        state_d  = ST_MEASURE;
                    end
                end else if (cnt_term) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    match_d   = '0;
                    state_d   = ST_TIMEOUT;
                end
            end

            ST_TIMEOUT: begin
                if (rise) begin
                    timeout_d = 1'b0;
                    match_d   = '0;
                    state_d   = ST_MEASURE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!meas_en_i) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            match_d   = '0;
            vld_d     = 1'b0;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
            range_d   = 1'b0;
        end
    end

    assign ratio_o     = ratio_q;
    assign ratio_vld_o = vld_q;
    assign locked_o    = locked_q;
    assign timeout_o   = timeout_q;
    assign range_err_o = range_q;

endmodule
